pc_unit_pipeline: RTL and testbench

Parametrised program-counter unit for the pipelined processor's IF stage. It holds the fetch PC and advances it sequentially. It also:
- applies branch/jump redirects and exception vectoring under a fixed priority;
- supports stall and halt/resume;
- flags when the fetch address is valid.

It sits between the next-PC selection logic and the instruction memory. It replaces the plain stall-able PC register.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_perf_counter.sv | 34 +++
 rtl/pc_unit_pipeline.sv | 123 ++++++++++++
 tb/tb_pc_unit_pipeline.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the IF-stage program-counter unit: the sequencing
// state type, default reset/exception vectors and the redirect alignment
// mask helper.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR_DEF   = 32'h8000_0004;

    // Widest PC the mask helper can describe; callers truncate to XLEN.
    localparam int unsigned PC_MASK_W = 64;

    // Clears the log2(inc) low bits; inc is a power of two.
    function automatic logic [PC_MASK_W-1:0] pc_align_mask(input int unsigned inc);
        return ~(PC_MASK_W'(inc) - PC_MASK_W'(1));
    endfunction

endpackage

// File: rtl/pc_perf_counter.sv
// Wrapping event counter with async active-high reset; advances by one on
// every clock edge where en_i is high.
module pc_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment when enabled, wrap is natural modulo 2^CNT_W.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_unit_pipeline.sv
// IF-stage program counter: sequential advance, exception vectoring,
// branch/jump redirect, stall and halt/resume.
// Optional fetch performance counter enabled by defining PC_PERF_CNT_EN.
//
// state  | meaning
// BOOT   | one edge after reset release, pc held, no fetch issued
// RUN    | fetching, pc advances / redirects each edge
// HALTED | no fetch, pc held except for redirect or exception
module pc_unit_pipeline
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0]   EXC_VECTOR   = XLEN'(PC_EXC_VECTOR_DEF),
    parameter int unsigned       INC          = 4,
    parameter int unsigned       CNT_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            exc_req_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o
`ifdef PC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_count_o
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(pc_align_mask(INC));
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

    // Elaboration-time guard on parameters the arithmetic relies on.
    if (INC == 0 || (INC & (INC - 1)) != 0 || CNT_W == 0 || XLEN > PC_MASK_W) begin : g_param_check
        $error("pc_unit_pipeline: INC must be a power of two, CNT_W nonzero, XLEN <= 64");
    end

    pc_state_e       state_q;
    pc_state_e       state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fetch_valid_q;
    logic            fetch_valid_d;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc_i & ALIGN_MASK;

    // Next-state and next-pc selection; priorities differ between RUN and HALTED.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (exc_req_i) begin
                    pc_d = EXC_VECTOR;
                end else if (redirect_i) begin
                    pc_d = redirect_aligned;
                end else if (halt_i) begin
                    state_d = ST_HALTED;
                end else if (!stall_i) begin
                    pc_d = pc_q + INC_X;
                end
            end
            ST_HALTED: begin
                if (exc_req_i) begin
                    pc_d    = EXC_VECTOR;
                    state_d = ST_RUN;
                end else if (resume_i) begin
                    state_d = ST_RUN;
                end else if (redirect_i) begin
                    pc_d = redirect_aligned;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // Valid is registered so it tracks the state it will describe.
        fetch_valid_d = (state_d == ST_RUN);
    end

    // State, pc and fetch-valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_q + INC_X;
    assign fetch_valid_o = fetch_valid_q;

`ifdef PC_PERF_CNT_EN
    logic fetch_accept;

    // A fetch is accepted when it is offered and the hazard unit lets it through.
    assign fetch_accept = fetch_valid_q & ~stall_i;

    pc_perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (fetch_accept),
        .count_o (fetch_count_o)
    );
`endif

endmodule

// File: tb/tb_pc_unit_pipeline.sv
// Bench for pc_unit_pipeline: directed table, hand-written reset/counter
// sequences and randomized traffic against a behavioural model.
module tb_pc_unit_pipeline;

    localparam logic [31:0] EXC = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect, exc, halt, resume;
    logic [31:0] rpc;
    logic [31:0] pc, pc_plus;
    logic        valid;
`ifdef PC_PERF_CNT_EN
    logic [31:0] cnt;
    logic [2:0]  cnt3;
    logic [31:0] pc3, pc_plus3;
    logic        valid3;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: pc, boot/halt flags and accepted-fetch count.
    logic [31:0] m_pc;
    bit          m_boot, m_halted;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    pc_unit_pipeline u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .exc_req_i     (exc),
        .halt_i        (halt),
        .resume_i      (resume),
        .pc_o          (pc),
        .pc_plus_o     (pc_plus),
        .fetch_valid_o (valid)
`ifdef PC_PERF_CNT_EN
        ,
        .fetch_count_o (cnt)
`endif
    );

`ifdef PC_PERF_CNT_EN
    pc_unit_pipeline #(.CNT_W(3)) u_dut3 (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .exc_req_i     (exc),
        .halt_i        (halt),
        .resume_i      (resume),
        .pc_o          (pc3),
        .pc_plus_o     (pc_plus3),
        .fetch_valid_o (valid3),
        .fetch_count_o (cnt3)
    );
`endif

    typedef struct {
        logic        stall, redirect;
        logic [31:0] rpc;
        logic        exc, halt, resume;
        logic [31:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] a,
                                input logic e, input logic h, input logic rs,
                                input logic [31:0] xp, input logic xv);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = a; v.exc = e; v.halt = h; v.resume = rs;
        v.exp_pc = xp; v.exp_valid = xv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; redirect = 0; rpc = '0; exc = 0; halt = 0; resume = 0;
    endtask

    // Spec rules for one rising edge, evaluated with the inputs about to be sampled.
    task automatic model_edge();
        bit offered;
        offered = !m_boot && !m_halted;
        if (offered && !stall) m_cnt = m_cnt + 1;
        if (m_boot) begin
            m_boot = 0;
        end else if (!m_halted) begin
            if (exc)           m_pc = EXC;
            else if (redirect) m_pc = {rpc[31:2], 2'b00};
            else if (halt)     m_halted = 1;
            else if (!stall)   m_pc = m_pc + 32'd4;
        end else begin
            if (exc) begin
                m_pc = EXC;
                m_halted = 0;
            end else if (resume) begin
                m_halted = 0;
            end else if (redirect) begin
                m_pc = {rpc[31:2], 2'b00};
            end
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_boot = 1; m_halted = 0; m_cnt = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_pc_plus"}, pc_plus, m_pc + 32'd4);
        chk({tag, "_valid"}, {31'b0, valid}, {31'b0, !m_boot && !m_halted});
`ifdef PC_PERF_CNT_EN
        chk({tag, "_count"}, cnt, m_cnt);
        chk({tag, "_count3"}, {29'b0, cnt3}, m_cnt & 32'd7);
        chk({tag, "_pc3"}, pc3, m_pc);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Full reset: asserted mid-cycle, held over one edge, released mid-cycle.
    task automatic do_reset();
        reset = 1;
        clear_inputs();
        model_reset();
        #1;
        chk("rst_async_pc", pc, 32'h0);
        chk("rst_async_valid", {31'b0, valid}, 32'h0);
        @(posedge clk);
        #1;
        check_model("rst_held");
        #3;
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        model_reset();

        tbl[0]  = mk(0, 0, 0,            0, 0, 0, 32'h0000_0000, 1);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0, 32'h0000_0004, 1);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0, 32'h0000_0008, 1);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0, 32'h0000_000C, 1);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0, 32'h0000_0010, 1);
        tbl[5]  = mk(1, 1, 32'h103,      0, 0, 0, 32'h0000_0100, 1);
        tbl[6]  = mk(0, 1, 32'h20,       0, 0, 0, 32'h0000_0020, 1);
        tbl[7]  = mk(0, 1, 32'h55,       1, 0, 0, EXC,           1);
        tbl[8]  = mk(1, 0, 0,            0, 0, 0, EXC,           1);
        tbl[9]  = mk(0, 1, 32'h40,       0, 0, 0, 32'h0000_0040, 1);
        tbl[10] = mk(0, 0, 0,            0, 1, 0, 32'h0000_0040, 0);
        tbl[11] = mk(1, 0, 0,            0, 1, 0, 32'h0000_0040, 0);
        tbl[12] = mk(0, 1, 32'h200,      0, 0, 0, 32'h0000_0200, 0);
        tbl[13] = mk(0, 0, 0,            0, 0, 1, 32'h0000_0200, 1);
        tbl[14] = mk(0, 0, 0,            0, 0, 0, 32'h0000_0204, 1);
        tbl[15] = mk(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFC, 1);
        tbl[16] = mk(0, 0, 0,            0, 0, 0, 32'h0000_0000, 1);
        tbl[17] = mk(0, 0, 0,            0, 1, 0, 32'h0000_0000, 0);
        tbl[18] = mk(0, 0, 0,            1, 0, 1, EXC,           1);
        tbl[19] = mk(1, 0, 0,            0, 1, 0, EXC,           0);
        tbl[20] = mk(0, 1, 32'h307,      0, 0, 1, EXC,           1);
        tbl[21] = mk(0, 0, 0,            0, 0, 0, 32'h8000_0008, 1);

        #2;
        do_reset();
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", {31'b0, valid}, 32'h0);

        foreach (tbl[i]) begin
            stall = tbl[i].stall; redirect = tbl[i].redirect; rpc = tbl[i].rpc;
            exc = tbl[i].exc; halt = tbl[i].halt; resume = tbl[i].resume;
            step();
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_pc_plus", i), pc_plus, tbl[i].exp_pc + 32'd4);
            chk($sformatf("tbl%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].exp_valid});
`ifdef PC_PERF_CNT_EN
            chk($sformatf("tbl%0d_count", i), cnt, m_cnt);
`endif
            clear_inputs();
        end

        // Async reset landing mid-cycle while a redirect is being requested.
        redirect = 1; rpc = 32'h500;
        #2;
        do_reset();
        step();
        check_model("post_rst_boot");
        chk("post_rst_pc", pc, 32'h0);

`ifdef PC_PERF_CNT_EN
        // Ten RUN edges with three stalls, then two more accepted fetches.
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            stall = (i == 2 || i == 5 || i == 7);
            step();
        end
        clear_inputs();
        chk("perf_7_count", cnt, 32'd7);
        step();
        step();
        chk("perf_9_count", cnt, 32'd9);
        chk("perf_9_count3", {29'b0, cnt3}, 32'd1);
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 5) == 0);
            rpc      = $urandom;
            exc      = ($urandom_range(0, 19) == 0);
            halt     = ($urandom_range(0, 14) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) begin
                exc = 0; redirect = 1; rpc = 32'hFFFF_FFF9;
            end
            step();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
